// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use stall, branch flush and forwarding control for a five-stage pipeline
//
// Purpose: detects load-use hazards and holds the front end for LOAD_LATENCY
// cycles, squashes younger pipeline registers on a taken branch/jump, selects
// EX-stage operand forwarding, and counts stall and flush cycles.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-low reset
//   ID_EX_*, IF_ID_*         stage source/destination specifiers and controls
//   EX_MEM_*, MEM_WB_*       writeback enables and destinations of older stages
//   BranchTaken              one-cycle redirect pulse (priority over stalls)
//   ClearCounters            synchronous clear of both event counters
//   PCWrite, IF_ID_Write     front-end load enables (low while stalling)
//   ID_EX_Bubble             zero control bits entering ID/EX
//   FlushMask                per-register squash strobes, bit 0 = IF/ID
//   ForwardA, ForwardB       00 = regfile, 10 = EX/MEM, 01 = MEM/WB
//   StallCount, FlushCount   saturating event counters
//   Busy                     high while in the multi-cycle stall state

module pipeline_hazard_controller #(
    parameter int REG_ADDR_BITS = 5,
    parameter int LOAD_LATENCY  = 1,
    parameter int FLUSH_DEPTH   = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ID_EX_MemRead,
    input  logic [REG_ADDR_BITS-1:0] ID_EX_RegisterRs,
    input  logic [REG_ADDR_BITS-1:0] ID_EX_RegisterRt,
    input  logic [REG_ADDR_BITS-1:0] IF_ID_RegisterRs,
    input  logic [REG_ADDR_BITS-1:0] IF_ID_RegisterRt,
    input  logic                     IF_ID_UsesRt,
    input  logic                     EX_MEM_RegWrite,
    input  logic                     MEM_WB_RegWrite,
    input  logic [REG_ADDR_BITS-1:0] EX_MEM_RegisterRd,
    input  logic [REG_ADDR_BITS-1:0] MEM_WB_RegisterRd,
    input  logic                     BranchTaken,
    input  logic                     ClearCounters,
    output logic                     PCWrite,
    output logic                     IF_ID_Write,
    output logic                     ID_EX_Bubble,
    output logic [FLUSH_DEPTH-1:0]   FlushMask,
    output logic [1:0]               ForwardA,
    output logic [1:0]               ForwardB,
    output logic [COUNT_WIDTH-1:0]   StallCount,
    output logic [COUNT_WIDTH-1:0]   FlushCount,
    output logic                     Busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } stateType;

    // The hazard cycle itself is the first stall cycle, so STALL covers the rest.
    localparam logic [2:0]             STALL_RELOAD = 3'(LOAD_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE    = COUNT_WIDTH'(1);

    stateType state;
    logic [2:0] cnt;
    logic hazard;
    logic stallNow;

    function automatic logic [1:0] forwardSel(
        input logic                     exMemWrite,
        input logic [REG_ADDR_BITS-1:0] exMemRd,
        input logic                     memWbWrite,
        input logic [REG_ADDR_BITS-1:0] memWbRd,
        input logic [REG_ADDR_BITS-1:0] src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (exMemWrite && exMemRd != '0 && exMemRd == src) begin
            sel = 2'b10;
        end else if (memWbWrite && memWbRd != '0 && memWbRd == src) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        hazard = ID_EX_MemRead && (ID_EX_RegisterRt != '0) &&
                 ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                  (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
        // A taken branch wins: the stalled instructions are being squashed anyway.
        stallNow = !BranchTaken && ((state == STALL) || hazard);
    end

    // Mealy outputs; all forced to their idle values while reset is held.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        FlushMask    = '0;
        ForwardA     = 2'b00;
        ForwardB     = 2'b00;
        if (reset) begin
            PCWrite      = !stallNow;
            IF_ID_Write  = !stallNow;
            ID_EX_Bubble = stallNow || BranchTaken;
            FlushMask    = BranchTaken ? '1 : '0;
            ForwardA     = forwardSel(EX_MEM_RegWrite, EX_MEM_RegisterRd,
                                      MEM_WB_RegWrite, MEM_WB_RegisterRd,
                                      ID_EX_RegisterRs);
            ForwardB     = forwardSel(EX_MEM_RegWrite, EX_MEM_RegisterRd,
                                      MEM_WB_RegWrite, MEM_WB_RegisterRd,
                                      ID_EX_RegisterRt);
        end
    end

    assign Busy = (state == STALL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (BranchTaken) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (state == STALL) begin
            // The hazard is not re-examined here; the load result is simply awaited.
            if (cnt == 3'd1) begin
                state <= IDLE;
            end
            cnt <= cnt - 3'd1;
        end else if (hazard && LOAD_LATENCY > 1) begin
            state <= STALL;
            cnt   <= STALL_RELOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (ClearCounters) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stallNow && StallCount != COUNT_MAX) begin
                StallCount <= StallCount + COUNT_ONE;
            end
            if (BranchTaken && FlushCount != COUNT_MAX) begin
                FlushCount <= FlushCount + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - randomized and directed bench for pipeline_hazard_controller

module tb_pipeline_hazard_controller;

    logic clk;
    logic reset;
    logic memRead, usesRt, exMemW, memWbW, branch, clr;
    logic [4:0] exRs, exRt, idRs, idRt, exMemRd, memWbRd;

    logic pcwV [3];
    logic ifidV [3];
    logic bubV [3];
    logic busyV [3];
    logic [1:0] fwdAV [3];
    logic [1:0] fwdBV [3];
    logic [3:0] flushA, flushB;
    logic [1:0] flushC;
    logic [15:0] sCntA, fCntA;
    logic [3:0] sCntB, fCntB, sCntC, fCntC;

    // Instance configurations: latency, flush depth, counter width.
    int latCfg [3] = '{1, 3, 7};
    int fdCfg  [3] = '{4, 4, 2};
    int cwCfg  [3] = '{16, 4, 4};

    pipeline_hazard_controller #(.REG_ADDR_BITS(5), .LOAD_LATENCY(1), .FLUSH_DEPTH(4), .COUNT_WIDTH(16)) dutA (
        .clk(clk), .reset(reset), .ID_EX_MemRead(memRead),
        .ID_EX_RegisterRs(exRs), .ID_EX_RegisterRt(exRt),
        .IF_ID_RegisterRs(idRs), .IF_ID_RegisterRt(idRt), .IF_ID_UsesRt(usesRt),
        .EX_MEM_RegWrite(exMemW), .MEM_WB_RegWrite(memWbW),
        .EX_MEM_RegisterRd(exMemRd), .MEM_WB_RegisterRd(memWbRd),
        .BranchTaken(branch), .ClearCounters(clr),
        .PCWrite(pcwV[0]), .IF_ID_Write(ifidV[0]), .ID_EX_Bubble(bubV[0]),
        .FlushMask(flushA), .ForwardA(fwdAV[0]), .ForwardB(fwdBV[0]),
        .StallCount(sCntA), .FlushCount(fCntA), .Busy(busyV[0]));

    pipeline_hazard_controller #(.REG_ADDR_BITS(5), .LOAD_LATENCY(3), .FLUSH_DEPTH(4), .COUNT_WIDTH(4)) dutB (
        .clk(clk), .reset(reset), .ID_EX_MemRead(memRead),
        .ID_EX_RegisterRs(exRs), .ID_EX_RegisterRt(exRt),
        .IF_ID_RegisterRs(idRs), .IF_ID_RegisterRt(idRt), .IF_ID_UsesRt(usesRt),
        .EX_MEM_RegWrite(exMemW), .MEM_WB_RegWrite(memWbW),
        .EX_MEM_RegisterRd(exMemRd), .MEM_WB_RegisterRd(memWbRd),
        .BranchTaken(branch), .ClearCounters(clr),
        .PCWrite(pcwV[1]), .IF_ID_Write(ifidV[1]), .ID_EX_Bubble(bubV[1]),
        .FlushMask(flushB), .ForwardA(fwdAV[1]), .ForwardB(fwdBV[1]),
        .StallCount(sCntB), .FlushCount(fCntB), .Busy(busyV[1]));

    pipeline_hazard_controller #(.REG_ADDR_BITS(5), .LOAD_LATENCY(7), .FLUSH_DEPTH(2), .COUNT_WIDTH(4)) dutC (
        .clk(clk), .reset(reset), .ID_EX_MemRead(memRead),
        .ID_EX_RegisterRs(exRs), .ID_EX_RegisterRt(exRt),
        .IF_ID_RegisterRs(idRs), .IF_ID_RegisterRt(idRt), .IF_ID_UsesRt(usesRt),
        .EX_MEM_RegWrite(exMemW), .MEM_WB_RegWrite(memWbW),
        .EX_MEM_RegisterRd(exMemRd), .MEM_WB_RegisterRd(memWbRd),
        .BranchTaken(branch), .ClearCounters(clr),
        .PCWrite(pcwV[2]), .IF_ID_Write(ifidV[2]), .ID_EX_Bubble(bubV[2]),
        .FlushMask(flushC), .ForwardA(fwdAV[2]), .ForwardB(fwdBV[2]),
        .StallCount(sCntC), .FlushCount(fCntC), .Busy(busyV[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a load-use hazard seen in a free cycle t blocks the
    // front end through cycle t+LOAD_LATENCY-1; freeUntil is the first cycle
    // that is no longer forced to stall.
    int cycleNo = 0;
    int freeUntil [3];
    int stallRef [3];
    int flushRef [3];
    bit stallPend [3];

    function automatic bit refHazard();
        return memRead && exRt != 0 &&
               (exRt == idRs || (usesRt && exRt == idRt));
    endfunction

    function automatic logic [1:0] refForward(input logic [4:0] src);
        if (exMemW && exMemRd != 0 && exMemRd == src) return 2'b10;
        if (memWbW && memWbRd != 0 && memWbRd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkCycle();
        bit hz, forced, stall;
        logic [31:0] fl, sc, fc;
        hz = refHazard();
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                freeUntil[i] = 0;
                stallRef[i] = 0;
                flushRef[i] = 0;
            end
            forced = reset && (cycleNo < freeUntil[i]);
            stall = reset && !branch && (forced || hz);
            stallPend[i] = stall;
            case (i)
                0: begin fl = 32'(flushA); sc = 32'(sCntA); fc = 32'(fCntA); end
                1: begin fl = 32'(flushB); sc = 32'(sCntB); fc = 32'(fCntB); end
                default: begin fl = 32'(flushC); sc = 32'(sCntC); fc = 32'(fCntC); end
            endcase
            checkVal($sformatf("pcw[%0d]", i), 32'(pcwV[i]), 32'(!stall));
            checkVal($sformatf("ifid[%0d]", i), 32'(ifidV[i]), 32'(!stall));
            checkVal($sformatf("bubble[%0d]", i), 32'(bubV[i]), 32'(stall || (reset && branch)));
            checkVal($sformatf("flush[%0d]", i), fl, (reset && branch) ? (32'(1) << fdCfg[i]) - 1 : 32'd0);
            checkVal($sformatf("busy[%0d]", i), 32'(busyV[i]), 32'(forced));
            checkVal($sformatf("fwdA[%0d]", i), 32'(fwdAV[i]), reset ? 32'(refForward(exRs)) : 32'd0);
            checkVal($sformatf("fwdB[%0d]", i), 32'(fwdBV[i]), reset ? 32'(refForward(exRt)) : 32'd0);
            checkVal($sformatf("stallCnt[%0d]", i), sc, 32'(stallRef[i]));
            checkVal($sformatf("flushCnt[%0d]", i), fc, 32'(flushRef[i]));
        end
    endtask

    task automatic updateModel();
        int maxCnt;
        for (int i = 0; i < 3; i++) begin
            maxCnt = (1 << cwCfg[i]) - 1;
            if (!reset) begin
                freeUntil[i] = 0;
                stallRef[i] = 0;
                flushRef[i] = 0;
            end else begin
                if (branch) freeUntil[i] = 0;
                else if (stallPend[i] && !(cycleNo < freeUntil[i])) freeUntil[i] = cycleNo + latCfg[i];
                if (clr) begin
                    stallRef[i] = 0;
                    flushRef[i] = 0;
                end else begin
                    if (stallPend[i] && stallRef[i] < maxCnt) stallRef[i]++;
                    if (branch && flushRef[i] < maxCnt) flushRef[i]++;
                end
            end
        end
        cycleNo++;
    endtask

    // Called shortly after a falling edge with inputs already applied.
    task automatic step();
        #1;
        checkCycle();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        {memRead, usesRt, exMemW, memWbW, branch, clr} = '0;
        {exRs, exRt, idRs, idRt, exMemRd, memWbRd} = '0;
        for (int i = 0; i < 3; i++) begin
            freeUntil[i] = 0; stallRef[i] = 0; flushRef[i] = 0; stallPend[i] = 0;
        end
        @(negedge clk);

        // Reset held with a hazard present.
        memRead = 1; exRt = 8; idRs = 8;
        repeat (3) begin
            #1;
            checkVal("rst_pcw", 32'(pcwV[0]), 1);
            checkVal("rst_bubble", 32'(bubV[0]), 0);
            checkVal("rst_flush", 32'(flushA), 0);
            checkVal("rst_stallcnt", 32'(sCntA), 0);
            step();
        end

        // Load-use pulsed for one cycle.
        reset = 1;
        #1;
        checkVal("lu_pcwA", 32'(pcwV[0]), 0);
        checkVal("lu_ifidA", 32'(ifidV[0]), 0);
        checkVal("lu_bubA", 32'(bubV[0]), 1);
        checkVal("lu_busyA", 32'(busyV[0]), 0);
        checkVal("lu_pcwB1", 32'(pcwV[1]), 0);
        checkVal("lu_busyB1", 32'(busyV[1]), 0);
        step();
        memRead = 0;
        #1;
        checkVal("lu_pcwA2", 32'(pcwV[0]), 1);
        checkVal("lu_pcwB2", 32'(pcwV[1]), 0);
        checkVal("lu_busyB2", 32'(busyV[1]), 1);
        step();
        #1;
        checkVal("lu_pcwB3", 32'(pcwV[1]), 0);
        checkVal("lu_busyB3", 32'(busyV[1]), 1);
        step();
        #1;
        checkVal("lu_pcwB4", 32'(pcwV[1]), 1);
        checkVal("lu_busyB4", 32'(busyV[1]), 0);
        checkVal("lu_stallcntA", 32'(sCntA), 1);
        checkVal("lu_stallcntB", 32'(sCntB), 3);
        step();

        // Rt = 0 never stalls; rt-only match needs IF_ID_UsesRt.
        memRead = 1; exRt = 0; idRs = 0;
        #1; checkVal("rt0_pcwA", 32'(pcwV[0]), 1);
        step();
        exRt = 9; idRs = 1; idRt = 9; usesRt = 0;
        #1;
        checkVal("nort_pcwA", 32'(pcwV[0]), 1);
        checkVal("nort_pcwB", 32'(pcwV[1]), 1);
        step();
        usesRt = 1;
        #1; checkVal("rt_pcwA", 32'(pcwV[0]), 0);
        step();
        memRead = 0; usesRt = 0;
        repeat (10) step();
        clr = 1;
        step();
        clr = 0;
        #1;
        checkVal("clr_stallcntB", 32'(sCntB), 0);
        checkVal("clr_flushcntB", 32'(fCntB), 0);

        // Branch in stall cycle 2.
        memRead = 1; exRt = 8; idRs = 8;
        step();
        memRead = 0; branch = 1;
        #1;
        checkVal("br_flushB", 32'(flushB), 32'hf);
        checkVal("br_flushC", 32'(flushC), 32'h3);
        checkVal("br_pcwB", 32'(pcwV[1]), 1);
        checkVal("br_bubB", 32'(bubV[1]), 1);
        checkVal("br_busyB", 32'(busyV[1]), 1);
        step();
        branch = 0;
        #1;
        checkVal("br_busyB_after", 32'(busyV[1]), 0);
        checkVal("br_pcwB_after", 32'(pcwV[1]), 1);
        checkVal("br_stallcntB", 32'(sCntB), 1);
        checkVal("br_flushcntB", 32'(fCntB), 1);
        step();

        // Forwarding priorities.
        exMemW = 1; exMemRd = 5; memWbW = 1; memWbRd = 5; exRs = 5;
        #1; checkVal("fwd_exmem", 32'(fwdAV[0]), 32'h2);
        exMemW = 0;
        #1; checkVal("fwd_memwb", 32'(fwdAV[0]), 32'h1);
        step();
        exMemW = 1; exMemRd = 0; memWbRd = 0; exRs = 0;
        #1; checkVal("fwd_rd0", 32'(fwdAV[0]), 32'h0);
        exMemRd = 7; exRt = 7;
        #1; checkVal("fwd_b", 32'(fwdBV[0]), 32'h2);
        step();

        // Saturation and clear during a stall.
        exMemW = 0; memWbW = 0; memRead = 0; clr = 1;
        step();
        clr = 0; memRead = 1; exRt = 8; idRs = 8; usesRt = 0;
        repeat (20) step();
        #1;
        checkVal("sat_stallcntB", 32'(sCntB), 15);
        checkVal("sat_stallcntA", 32'(sCntA), 20);
        clr = 1;
        step();
        clr = 0;
        #1;
        checkVal("satclr_stallcntB", 32'(sCntB), 0);
        checkVal("satclr_stallcntA", 32'(sCntA), 0);
        memRead = 0;
        step();

        // Randomized traffic, including async reset pulses mid-stall.
        repeat (3000) begin
            reset   = ($urandom_range(0, 63) != 0);
            memRead = ($urandom_range(0, 1) != 0);
            usesRt  = ($urandom_range(0, 1) != 0);
            exMemW  = ($urandom_range(0, 1) != 0);
            memWbW  = ($urandom_range(0, 1) != 0);
            branch  = ($urandom_range(0, 7) == 0);
            clr     = ($urandom_range(0, 31) == 0);
            exRs    = 5'($urandom_range(0, 3));
            exRt    = 5'($urandom_range(0, 3));
            idRs    = 5'($urandom_range(0, 3));
            idRt    = 5'($urandom_range(0, 3));
            exMemRd = 5'($urandom_range(0, 3));
            memWbRd = 5'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
